// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad scanner and its helpers:
//   state_t  - scanner FSM state encoding (also visible on the debug port)
//   STATE_W  - width of the encoded state
//   clog2()  - elaboration-time ceiling log2 used to size counters and indices
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_DEB_PRESS = 3'd2,
        ST_PRESSED   = 3'd3,
        ST_DEB_REL   = 3'd4
    } state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_tick_gen
// Free-running prescaler that emits a one-cycle strobe every TICK_DIV clocks.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   o_tick   registered one-cycle strobe, period TICK_DIV cycles
// -----------------------------------------------------------------------------
module keypad_tick_gen
    import keypad_pkg::*;
#(
    parameter int TICK_DIV = 262144
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt    <= '0;
            o_tick <= 1'b1;
        end else begin
            cnt    <= cnt + CW'(1);
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner_multi.sv
// -----------------------------------------------------------------------------
// keypad_scanner_multi
// ROWS x COLS matrix keypad scanner. Columns are driven active-low one at a
// time, rows are sampled active-low through a 2-flop synchroniser, and both
// press and release are debounced over DEBOUNCE_TICKS scan ticks.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_row          raw row lines, 0 = pressed (asynchronous)
//   o_col          column drive, active-low (all low while idle)
//   o_key_code     row_idx*COLS + col_idx of the last accepted key
//   o_key_valid    one-cycle pulse on a debounced press
//   o_key_held     level, accepted key currently held
//   o_key_release  one-cycle pulse on a debounced release
//   o_multi_key    one-cycle pulse when >1 row is low in the scanned column
//   o_dbg_state    current FSM state (keypad_pkg::state_t encoding)
//
// Output event protocol: o_key_valid, o_key_release and o_multi_key are
// single-cycle, mutually exclusive strobes with no ready/backpressure; a
// consumer must sample them every cycle. o_key_code is stable whenever any
// strobe is high and only changes together with o_key_valid.
// -----------------------------------------------------------------------------
module keypad_scanner_multi
    import keypad_pkg::*;
#(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int TICK_DIV       = 262144,
    parameter  int DEBOUNCE_TICKS = 3,
    localparam int CODE_W         = clog2(ROWS * COLS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [ROWS-1:0]     i_row,
    output logic [COLS-1:0]     o_col,
    output logic [CODE_W-1:0]   o_key_code,
    output logic                o_key_valid,
    output logic                o_key_held,
    output logic                o_key_release,
    output logic                o_multi_key,
    output logic [STATE_W-1:0]  o_dbg_state
);

    localparam int ROW_W = clog2(ROWS);
    localparam int COL_W = clog2(COLS);
    localparam int CNT_W = clog2(DEBOUNCE_TICKS + 1);

    logic              tick;
    logic [ROWS-1:0]   row_m;
    logic [ROWS-1:0]   row_s;
    state_t            state;
    logic [ROW_W-1:0]  row_idx;
    logic [COL_W-1:0]  col_idx;
    logic [CNT_W-1:0]  cnt;

    logic [3:0]        low_cnt;
    logic [ROW_W-1:0]  low_idx;
    logic              row_match;
    logic              col_last;
    logic              deb_done;
    logic [CODE_W-1:0] code_next;

    keypad_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (tick)
    );

    // Rows idle high, so the synchroniser resets to "nothing pressed".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= i_row;
            row_s <= row_m;
        end
    end

    // Count low rows and remember the index of a low row; the index is only
    // meaningful when exactly one row is low.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_s[r]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = ROW_W'(r);
            end
        end
    end

    assign row_match = (row_s == ~(ROWS'(1) << row_idx));
    assign col_last  = (col_idx == COL_W'(COLS - 1));
    // The tick that would take cnt to DEBOUNCE_TICKS completes the debounce.
    assign deb_done  = (cnt >= CNT_W'(DEBOUNCE_TICKS - 1));
    assign code_next = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);

    function automatic logic [COLS-1:0] drive_col(input logic [COL_W-1:0] idx);
        return ~(COLS'(1) << idx);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            o_col         <= '0;
            row_idx       <= '0;
            col_idx       <= '0;
            cnt           <= '0;
            o_key_code    <= '0;
            o_key_valid   <= 1'b0;
            o_key_held    <= 1'b0;
            o_key_release <= 1'b0;
            o_multi_key   <= 1'b0;
        end else begin
            o_key_valid   <= 1'b0;
            o_key_release <= 1'b0;
            o_multi_key   <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (low_cnt != 4'd0) begin
                            state   <= ST_SCAN;
                            col_idx <= '0;
                            o_col   <= drive_col(COL_W'(0));
                        end
                    end
                    ST_SCAN: begin
                        if (low_cnt == 4'd0) begin
                            if (col_last) begin
                                // Whole matrix empty: the wake-up was a glitch.
                                state   <= ST_IDLE;
                                col_idx <= '0;
                                o_col   <= '0;
                            end else begin
                                col_idx <= col_idx + COL_W'(1);
                                o_col   <= drive_col(col_idx + COL_W'(1));
                            end
                        end else if (low_cnt == 4'd1) begin
                            row_idx <= low_idx;
                            cnt     <= CNT_W'(1);
                            state   <= ST_DEB_PRESS;
                        end else begin
                            o_multi_key <= 1'b1;
                            state       <= ST_IDLE;
                            col_idx     <= '0;
                            o_col       <= '0;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (row_match) begin
                            if (deb_done) begin
                                state       <= ST_PRESSED;
                                cnt         <= '0;
                                o_key_code  <= code_next;
                                o_key_valid <= 1'b1;
                                o_key_held  <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state   <= ST_IDLE;
                            cnt     <= '0;
                            col_idx <= '0;
                            o_col   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // Only the accepted row matters; other rows in this
                        // column are deliberately ignored while held.
                        if (row_s[row_idx]) begin
                            cnt   <= CNT_W'(1);
                            state <= ST_DEB_REL;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_DEB_REL: begin
                        if (row_s[row_idx]) begin
                            if (deb_done) begin
                                state         <= ST_IDLE;
                                cnt           <= '0;
                                col_idx       <= '0;
                                o_col         <= '0;
                                o_key_release <= 1'b1;
                                o_key_held    <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= ST_PRESSED;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        col_idx <= '0;
                        o_col   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_dbg_state = state;

endmodule

// File: tb/tb_keypad_scanner_multi.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner_multi
// Two scanner instances (4x4 and 2x8) driven by a behavioural keypad matrix.
// Expected events are pushed into per-instance queues at stimulus time and
// popped by independent monitors whenever the DUT strobes an event.
// -----------------------------------------------------------------------------
module tb_keypad_scanner_multi;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int RA = 4;
    localparam int CA = 4;
    localparam int RB = 2;
    localparam int CB = 8;

    localparam int EV_VALID = 1;
    localparam int EV_REL   = 2;
    localparam int EV_MULTI = 3;

    logic          clk;
    logic          rst_n;

    logic [RA-1:0] row_a;
    logic [CA-1:0] col_a;
    logic [3:0]    code_a;
    logic          valid_a, held_a, rel_a, multi_a;
    logic [2:0]    st_a;

    logic [RB-1:0] row_b;
    logic [CB-1:0] col_b;
    logic [3:0]    code_b;
    logic          valid_b, held_b, rel_b, multi_b;
    logic [2:0]    st_b;

    logic [15:0]   key_a;
    logic [15:0]   key_b;

    logic [5:0]    exp_q_a[$];
    logic [5:0]    exp_q_b[$];
    int            last_code_a;

    int            n_tests;
    int            n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    keypad_scanner_multi #(
        .ROWS(RA), .COLS(CA), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_row(row_a), .o_col(col_a),
        .o_key_code(code_a), .o_key_valid(valid_a), .o_key_held(held_a),
        .o_key_release(rel_a), .o_multi_key(multi_a), .o_dbg_state(st_a)
    );

    keypad_scanner_multi #(
        .ROWS(RB), .COLS(CB), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_row(row_b), .o_col(col_b),
        .o_key_code(code_b), .o_key_valid(valid_b), .o_key_held(held_b),
        .o_key_release(rel_b), .o_multi_key(multi_b), .o_dbg_state(st_b)
    );

    // ---------------- keypad matrix model ----------------
    // A row reads low when any pressed key on it sits in a driven column.
    always_comb begin
        row_a = '1;
        for (int r = 0; r < RA; r++)
            for (int c = 0; c < CA; c++)
                if (key_a[r*CA+c] && !col_a[c]) row_a[r] = 1'b0;
    end

    always_comb begin
        row_b = '1;
        for (int r = 0; r < RB; r++)
            for (int c = 0; c < CB; c++)
                if (key_b[r*CB+c] && !col_b[c]) row_b[r] = 1'b0;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input int typ, input int code);
        exp_q_a.push_back({typ[1:0], code[3:0]});
    endtask

    task automatic push_b(input int typ, input int code);
        exp_q_b.push_back({typ[1:0], code[3:0]});
    endtask

    // Advance n scan ticks; returns #1 after the edge that consumed the tick.
    task automatic tick_a(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!dut_a.tick && k < 4*TD);
            if (!dut_a.tick) check("a_tick_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_b(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!dut_b.tick && k < 4*TD);
            if (!dut_b.tick) check("b_tick_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic period_check();
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!dut_a.tick && k < 4*TD);
        k = 0;
        do begin @(negedge clk); k++; end while (!dut_a.tick && k < 4*TD);
        check("tick_period", k, TD);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin : mon_a
        int typ;
        logic [5:0] e;
        if (rst_n && (valid_a || rel_a || multi_a)) begin
            check("a_pulse_excl", int'(valid_a) + int'(rel_a) + int'(multi_a), 1);
            typ = valid_a ? EV_VALID : (rel_a ? EV_REL : EV_MULTI);
            if (exp_q_a.size() == 0) begin
                check("a_unexpected_event", typ, 0);
            end else begin
                e = exp_q_a.pop_front();
                check("a_event_type", typ, int'(e[5:4]));
                check("a_event_code", int'(code_a), int'(e[3:0]));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        int typ;
        logic [5:0] e;
        if (rst_n && (valid_b || rel_b || multi_b)) begin
            check("b_pulse_excl", int'(valid_b) + int'(rel_b) + int'(multi_b), 1);
            typ = valid_b ? EV_VALID : (rel_b ? EV_REL : EV_MULTI);
            if (exp_q_b.size() == 0) begin
                check("b_unexpected_event", typ, 0);
            end else begin
                e = exp_q_b.pop_front();
                check("b_event_type", typ, int'(e[5:4]));
                check("b_event_code", int'(code_b), int'(e[3:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, c, r2, h, code, kind, nm;
        n_tests     = 0;
        n_fail      = 0;
        key_a       = '0;
        key_b       = '0;
        last_code_a = 0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_a", int'(col_a), 0);
        check("rst_code_a", int'(code_a), 0);
        check("rst_held_a", int'(held_a), 0);
        check("rst_pulses_a", int'({valid_a, rel_a, multi_a}), 0);
        check("rst_state_a", int'(st_a), 0);
        check("rst_col_b", int'(col_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        period_check();
        period_check();

        // S1: key (2,1) held 20 ticks -> code 9, held level, one release
        tick_a(1);
        push_a(EV_VALID, 9);
        push_a(EV_REL, 9);
        key_a[2*CA+1] = 1'b1;
        tick_a(1 + 1 + DB);
        check("s1_valid_on_time", int'(valid_a), 1);
        tick_a(1);
        check("s1_held_early", int'(held_a), 1);
        tick_a(14);
        check("s1_held_late", int'(held_a), 1);
        key_a = '0;
        tick_a(DB);
        check("s1_release_on_time", int'(rel_a), 1);
        tick_a(CA + 2);
        check("s1_code_kept", int'(code_a), 9);
        check("s1_held_clear", int'(held_a), 0);
        last_code_a = 9;

        // S2: key (0,3) bounces, then stable -> exactly one press, code 3
        key_a[3] = 1'b1; tick_a(1);
        key_a[3] = 1'b0; tick_a(1);
        key_a[3] = 1'b1; tick_a(1);
        key_a[3] = 1'b0; tick_a(1);
        push_a(EV_VALID, 3);
        push_a(EV_REL, 3);
        key_a[3] = 1'b1;
        tick_a(20);
        check("s2_held", int'(held_a), 1);
        key_a = '0;
        tick_a(CA + DB + 3);
        check("s2_code", int'(code_a), 3);
        last_code_a = 3;

        // S3: rows 0 and 3 low in column 0 for 5 ticks -> multi every 2 ticks
        push_a(EV_MULTI, last_code_a);
        push_a(EV_MULTI, last_code_a);
        key_a[0*CA+0] = 1'b1;
        key_a[3*CA+0] = 1'b1;
        tick_a(2);
        check("s3_multi_on_time", int'(multi_a), 1);
        tick_a(3);
        key_a = '0;
        tick_a(CA + DB + 3);
        check("s3_state_idle", int'(st_a), 0);
        check("s3_col_idle", int'(col_a), 0);

        // S4: one-tick glitch on row 1 -> scan runs out, no events
        key_a[1*CA+2] = 1'b1;
        tick_a(1);
        key_a = '0;
        check("s4_scan_col0", int'(col_a), 4'he);
        tick_a(CA + 1);
        check("s4_col_idle", int'(col_a), 0);
        check("s4_state_idle", int'(st_a), 0);

        // S5: release bounce high2/low1/high3 -> release on 3rd high tick
        push_a(EV_VALID, 5);
        push_a(EV_REL, 5);
        key_a[1*CA+1] = 1'b1;
        tick_a(10);
        check("s5_held", int'(held_a), 1);
        key_a = '0;           tick_a(2);
        check("s5_held_bounce1", int'(held_a), 1);
        key_a[1*CA+1] = 1'b1; tick_a(1);
        check("s5_held_bounce2", int'(held_a), 1);
        key_a = '0;           tick_a(2);
        check("s5_no_early_release", int'(rel_a), 0);
        tick_a(1);
        check("s5_release_3rd_high", int'(rel_a), 1);
        tick_a(CA + DB + 3);
        last_code_a = 5;

        // S6: reset while pressed, key still held afterwards -> fresh press
        push_a(EV_VALID, 9);
        key_a[2*CA+1] = 1'b1;
        tick_a(1 + 1 + DB + 1);
        check("s6_held_before_rst", int'(held_a), 1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_col", int'(col_a), 0);
        check("s6_rst_code", int'(code_a), 0);
        check("s6_rst_held", int'(held_a), 0);
        check("s6_rst_pulses", int'({valid_a, rel_a, multi_a}), 0);
        push_a(EV_VALID, 9);
        push_a(EV_REL, 9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick_a(1);
        tick_a(8);
        check("s6_held_after_rst", int'(held_a), 1);
        check("s6_code_after_rst", int'(code_a), 9);
        key_a = '0;
        tick_a(CA + DB + 3);
        last_code_a = 9;

        // Random trials against the tick-level model
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(0, 3);
            c    = $urandom_range(0, CA - 1);
            r    = $urandom_range(0, RA - 1);
            if (kind == 0) begin
                // Same-column pair: a multi strobe every (c+2) ticks of hold
                r2 = (r + $urandom_range(1, RA - 1)) % RA;
                h  = $urandom_range(2, 8);
                nm = h / (c + 2);
                for (int m = 0; m < nm; m++) push_a(EV_MULTI, last_code_a);
                key_a[r*CA+c]  = 1'b1;
                key_a[r2*CA+c] = 1'b1;
            end else begin
                // Single key: accepted only if visible for c+1+DB ticks
                h    = $urandom_range(c + DB - 1, c + DB + 3);
                code = r*CA + c;
                if (h >= c + 1 + DB) begin
                    push_a(EV_VALID, code);
                    push_a(EV_REL, code);
                    last_code_a = code;
                end
                key_a[r*CA+c] = 1'b1;
            end
            tick_a(h);
            key_a = '0;
            tick_a(CA + DB + 3);
        end
        check("rand_code_kept", int'(code_a), last_code_a);

        // Sweep on the 2x8 instance: every code maps to row*8+col
        tick_b(1);
        for (int rr = 0; rr < RB; rr++) begin
            for (int cc = 0; cc < CB; cc++) begin
                code = rr*CB + cc;
                push_b(EV_VALID, code);
                push_b(EV_REL, code);
                key_b[code] = 1'b1;
                tick_b(cc + 1 + DB + 2);
                check("b_sweep_held", int'(held_b), 1);
                key_b = '0;
                tick_b(CB + DB + 3);
            end
        end

        tick_a(4);
        check("a_queue_drained", exp_q_a.size(), 0);
        check("b_queue_drained", exp_q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
